// File: rtl/intv_timer_arb_pkg.sv
// Shared types and helpers for the interval-timer arbiter: FSM state encoding,
// counter limits and the round-robin selection function.
package intv_pkg;

   localparam int W_DEF   = 3;
   localparam int CNT_MAX = (1 << W_DEF) - 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      COUNT = 2'd2,
      DONE  = 2'd3
   } state_t;

   // First asserted requester after `last`, searching cyclically over n requesters.
   function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] last, input int n);
      logic [1:0] pick;
      logic [1:0] sel;
      logic       found;
      int         idx;
      pick  = last;
      found = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         idx = (int'(last) + i) % n;
         sel = 2'(idx);
         if (i <= n && !found && req[sel]) begin
            pick  = sel;
            found = 1'b1;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/intv_timer_arb_if.sv
// Requester-side bundle of the interval-timer arbiter: request/length inputs,
// grant/done/busy status and the observed counter value.
interface intv_timer_arb_if #(
   parameter int N_REQ = 2,
   parameter int W     = intv_pkg::W_DEF
);
   logic [N_REQ-1:0]   req;
   logic [N_REQ*W-1:0] len;
   logic [N_REQ-1:0]   gnt;
   logic [N_REQ-1:0]   done;
   logic               busy;
   logic [W-1:0]       cnt;

   modport master (output req, len, input gnt, done, busy, cnt);
   modport slave  (input req, len, output gnt, done, busy, cnt);
endinterface

// File: rtl/intv_timer_arb_ld_counter.sv
// Loadable W-bit synchronous up-counter; load wins over enable, wraps modulo 2^W.
module ld_counter #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         nrst,
   input  logic         ld,
   input  logic [W-1:0] d,
   input  logic         en,
   output logic [W-1:0] q
);
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         q <= '0;
      end else if (ld) begin
         q <= d;
      end else if (en) begin
         q <= q + 1'b1;
      end
   end
endmodule

// File: rtl/intv_timer_arb.sv
// Round-robin scheduler sharing one loadable counter between N_REQ requesters;
// each granted interval runs len cycles (0 means 2^W) and ends with a done pulse.
module intv_timer_arb
   import intv_pkg::*;
#(
   parameter int N_REQ = 2,
   parameter int W     = W_DEF
) (
   input  logic             clk,
   input  logic             nrst,
   intv_timer_arb_if.slave  bus
);
   localparam logic [W-1:0] CNT_TOP = '1;

   state_t           state_reg;
   logic [1:0]       owner_reg;
   logic [1:0]       last_reg;
   logic [N_REQ-1:0] gnt_reg;
   logic [N_REQ-1:0] done_reg;
   logic             busy_reg;

   logic [1:0]       pick;
   logic [3:0]       req_ext;
   logic [W-1:0]     len_arr [4];
   logic [W-1:0]     len_own;
   logic [W-1:0]     ld_val;
   logic [W-1:0]     cnt_q;
   logic             req_own;
   logic             ld;
   logic             en;

   assign req_ext = 4'(bus.req);

   for (genvar gi = 0; gi < 4; gi++) begin : g_len
      if (gi < N_REQ) begin : g_used
         assign len_arr[gi] = bus.len[gi*W +: W];
      end else begin : g_unused
         assign len_arr[gi] = '0;
      end
   end

   assign pick    = rr_pick(req_ext, last_reg, N_REQ);
   assign req_own = req_ext[owner_reg];
   assign len_own = len_arr[owner_reg];
   // Starting at 2^W - len makes the wrap to zero land exactly len enables later.
   assign ld_val  = '0 - len_own;
   // Gating with req_own keeps cnt untouched on the abort edge.
   assign ld      = (state_reg == LOAD)  && req_own;
   assign en      = (state_reg == COUNT) && req_own;

   ld_counter #(.W(W)) u_cnt (
      .clk  (clk),
      .nrst (nrst),
      .ld   (ld),
      .d    (ld_val),
      .en   (en),
      .q    (cnt_q)
   );

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_reg <= IDLE;
         owner_reg <= '0;
         last_reg  <= 2'(N_REQ - 1);
         gnt_reg   <= '0;
         done_reg  <= '0;
         busy_reg  <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (|bus.req) begin
                  owner_reg <= pick;
                  gnt_reg   <= N_REQ'(4'b0001 << pick);
                  busy_reg  <= 1'b1;
                  state_reg <= LOAD;
               end
            end
            LOAD, COUNT: begin
               if (!req_own) begin
                  last_reg  <= owner_reg;
                  gnt_reg   <= '0;
                  busy_reg  <= 1'b0;
                  state_reg <= IDLE;
               end else if (state_reg == LOAD) begin
                  state_reg <= COUNT;
               end else if (cnt_q == CNT_TOP) begin
                  done_reg  <= gnt_reg;
                  state_reg <= DONE;
               end
            end
            DONE: begin
               last_reg  <= owner_reg;
               gnt_reg   <= '0;
               done_reg  <= '0;
               busy_reg  <= 1'b0;
               state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign bus.gnt  = gnt_reg;
   assign bus.done = done_reg;
   assign bus.busy = busy_reg;
   assign bus.cnt  = cnt_q;

endmodule

// File: tb/tb_intv_timer_arb.sv
// Self-checking bench for intv_timer_arb: vector table, directed corner sequences
// and randomized traffic against a transaction-age reference model.
module tb_intv_timer_arb;
   import intv_pkg::*;

   localparam int N_REQ = 2;
   localparam int W     = W_DEF;
   localparam int M     = CNT_MAX + 1;

   logic clk  = 1'b0;
   logic nrst = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   intv_timer_arb_if #(.N_REQ(N_REQ), .W(W)) bus ();
   intv_timer_arb #(.N_REQ(N_REQ), .W(W)) dut (.clk(clk), .nrst(nrst), .bus(bus));

   typedef struct {
      int who;
      int l;
      int lat;
      int cnt0;
   } vec_t;
   vec_t vt[8];

   // Reference model state: age 0 is the grant cycle, done appears at age leff+1.
   logic m_act;
   int   m_owner, m_last, m_age, m_leff, m_cnt, n_txn;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic timeout(input string name, input int limit);
      n_tests++;
      n_fail++;
      $display("FAIL %s: no event within %0d cycles", name, limit);
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_len(input int k, input int v);
      bus.len[k*W +: W] = W'(v);
   endtask

   function automatic int len_of(input int k);
      return int'(bus.len[k*W +: W]);
   endfunction

   task automatic wait_gnt(input int k, input string name);
      int c;
      c = 0;
      while (c < 30 && bus.gnt[k] !== 1'b1) begin
         tick();
         c++;
      end
      if (bus.gnt[k] !== 1'b1) timeout(name, 30);
   endtask

   task automatic wait_done(input string name);
      int c;
      c = 0;
      while (c < 30 && bus.done == '0) begin
         tick();
         c++;
      end
      if (bus.done == '0) timeout(name, 30);
   endtask

   task automatic model_step();
      int lo;
      if (!m_act) begin
         for (int i = 1; i <= N_REQ; i++) begin
            int idx;
            idx = (m_last + i) % N_REQ;
            if (!m_act && bus.req[idx]) begin
               m_act   = 1'b1;
               m_owner = idx;
               m_age   = 0;
            end
         end
      end else if (m_age >= 1 && m_age == m_leff + 1) begin
         m_act  = 1'b0;
         m_last = m_owner;
         n_txn++;
         $display("[TB] rnd txn %0d: owner=%0d cycles=%0d done", n_txn, m_owner, m_leff);
      end else if (!bus.req[m_owner]) begin
         m_act  = 1'b0;
         m_last = m_owner;
         n_txn++;
         $display("[TB] rnd txn %0d: owner=%0d aborted at age %0d", n_txn, m_owner, m_age);
      end else begin
         if (m_age == 0) begin
            lo     = len_of(m_owner);
            m_leff = (lo == 0) ? M : lo;
         end
         m_age++;
         m_cnt = (M - m_leff + m_age - 1) % M;
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, c0, cyc;
      int order[$];
      int tdone[$];
      logic [N_REQ-1:0] prev;
      logic [N_REQ-1:0] r;
      logic exp_busy;
      int exp_gnt, exp_done;

      vt[0] = '{0, 3, 5, 5};
      vt[1] = '{1, 0, 10, 0};
      vt[2] = '{0, 1, 3, 7};
      vt[3] = '{1, 7, 9, 1};
      vt[4] = '{0, 2, 4, 6};
      vt[5] = '{1, 5, 7, 3};
      vt[6] = '{0, 4, 6, 4};
      vt[7] = '{1, 6, 8, 2};

      bus.req = '0;
      bus.len = '0;
      repeat (2) @(negedge clk);
      check("rst_gnt", bus.gnt, 0);
      check("rst_done", bus.done, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_cnt", bus.cnt, 0);
      nrst = 1'b1;
      tick();

      // Single transactions from idle: latency, owner and first counted value.
      for (int i = 0; i < 8; i++) begin
         set_len(vt[i].who, vt[i].l);
         bus.req = N_REQ'(1 << vt[i].who);
         lat = 0;
         c0  = -1;
         while (lat < 20 && bus.done == '0) begin
            tick();
            lat++;
            if (lat == 1) check("tab_gnt_load", bus.gnt, 1 << vt[i].who);
            if (lat == 2) c0 = int'(bus.cnt);
         end
         check("tab_latency", lat, vt[i].lat);
         check("tab_done_owner", bus.done, 1 << vt[i].who);
         check("tab_first_cnt", c0, vt[i].cnt0);
         bus.req = '0;
         tick();
         check("tab_busy_after", bus.busy, 0);
         check("tab_gnt_after", bus.gnt, 0);
         $display("[TB] vec %0d: req%0d len=%0d latency=%0d first_cnt=%0d", i, vt[i].who, vt[i].l, lat, c0);
      end

      // Both requesters held: strict alternation with an idle cycle between dones.
      set_len(0, 1);
      set_len(1, 1);
      bus.req = '1;
      prev = '0;
      cyc  = 0;
      while (tdone.size() < 4 && cyc < 60) begin
         tick();
         cyc++;
         if (bus.gnt != '0 && prev == '0) order.push_back(bus.gnt[1] ? 1 : 0);
         if (bus.done != '0) begin
            check("rr_done_is_owner", bus.done, bus.gnt);
            tdone.push_back(cyc);
            if (tdone.size() == 4) bus.req = '0;
         end
         prev = bus.gnt;
      end
      check("rr_done_count", tdone.size(), 4);
      check("rr_grant_count", order.size(), 4);
      for (int i = 0; i < order.size(); i++) check("rr_order", order[i], i % 2);
      for (int i = 1; i < tdone.size(); i++) check("rr_done_spacing", tdone[i] - tdone[i-1], 4);
      $display("[TB] round-robin: %0d grants, %0d dones", order.size(), tdone.size());
      tick();

      // Abort after two COUNT cycles, pending requester 1 served next.
      set_len(0, 5);
      set_len(1, 2);
      bus.req = '1;
      wait_gnt(0, "abort_wait_gnt0");
      tick();
      tick();
      check("abort_cnt_before", bus.cnt, 4);
      bus.req[0] = 1'b0;
      tick();
      check("abort_gnt", bus.gnt, 0);
      check("abort_busy", bus.busy, 0);
      check("abort_done", bus.done, 0);
      check("abort_cnt_held", bus.cnt, 4);
      tick();
      check("abort_next_gnt", bus.gnt, 2);
      wait_done("abort_wait_done1");
      check("abort_next_done", bus.done, 2);
      bus.req = '0;
      tick();
      $display("[TB] abort: owner 0 aborted, owner 1 served");

      // Owner 0 completes so the pointer sits on 0 before the reset test.
      set_len(0, 1);
      bus.req = 2'b01;
      wait_done("pre_rst_done");
      bus.req = '0;
      tick();
      set_len(1, 3);
      bus.req = '1;
      wait_gnt(1, "rst_wait_gnt1");
      check("rst_mid_owner", bus.gnt, 2);
      tick();
      tick();
      check("rst_mid_cnt", bus.cnt, 6);
      #2 nrst = 1'b0;
      #1;
      check("rst_mid_gnt", bus.gnt, 0);
      check("rst_mid_done", bus.done, 0);
      check("rst_mid_busy", bus.busy, 0);
      check("rst_mid_cnt0", bus.cnt, 0);
      @(negedge clk);
      nrst = 1'b1;
      tick();
      check("rst_first_owner", bus.gnt, 1);
      wait_done("rst_after_done");
      check("rst_after_done_owner", bus.done, 1);
      bus.req = '0;
      tick();
      $display("[TB] reset mid-count: outputs cleared, requester 0 granted first");

      // len and non-owner req changes mid-interval are ignored.
      set_len(0, 2);
      bus.req = 2'b01;
      wait_gnt(0, "len_wait_gnt0");
      tick();
      set_len(0, 7);
      bus.req[1] = 1'b1;
      tick();
      check("len_chg_gnt", bus.gnt, 1);
      check("len_chg_nodone", bus.done, 0);
      tick();
      check("len_chg_done", bus.done, 1);
      bus.req[0] = 1'b0;
      tick();
      check("len_chg_idle_gnt", bus.gnt, 0);
      tick();
      check("len_chg_next_gnt", bus.gnt, 2);
      bus.req = '0;
      tick();
      check("len_chg_abort_busy", bus.busy, 0);
      $display("[TB] len change: interval kept at 2 cycles, req1 waited for idle");

      // Randomized traffic against the reference model.
      nrst = 1'b0;
      tick();
      nrst    = 1'b1;
      m_act   = 1'b0;
      m_owner = 0;
      m_last  = N_REQ - 1;
      m_age   = 0;
      m_leff  = 1;
      m_cnt   = 0;
      n_txn   = 0;
      for (int c = 0; c < 2000; c++) begin
         r = bus.req;
         for (int k = 0; k < N_REQ; k++) begin
            if (!r[k]) r[k] = ($urandom_range(0, 99) < 25);
            else if (bus.done[k]) r[k] = ($urandom_range(0, 99) < 30);
            else r[k] = ($urandom_range(0, 99) >= 3);
            if ($urandom_range(0, 99) < 20) set_len(k, int'($urandom_range(0, M - 1)));
         end
         bus.req = r;
         @(posedge clk);
         model_step();
         @(negedge clk);
         exp_gnt  = m_act ? (1 << m_owner) : 0;
         exp_busy = m_act;
         exp_done = (m_act && m_age >= 1 && m_age == m_leff + 1) ? (1 << m_owner) : 0;
         check("rnd_gnt", bus.gnt, exp_gnt);
         check("rnd_done", bus.done, exp_done);
         check("rnd_busy", bus.busy, exp_busy);
         check("rnd_cnt", bus.cnt, m_cnt);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/intv_timer_arb.md
Name: intv_timer_arb

Overview:
- Round-robin scheduler that shares one loadable W-bit synchronous up-counter between N_REQ requesters; each requester asks for a timed interval of `len` clock cycles.
- The controller arbitrates, loads the counter, enables it for the interval, then pulses `done` to the owner.
- Sits between interval consumers (wait states, pulse generators) and the shared counter datapath.

Parameters:
- N_REQ, 2, number of requesters (2..4).
- W, 3, counter and interval-length width.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- nrst  input  1  reset, asynchronous, active-low.
- req  input  N_REQ  per-requester request level; held high until `done`, or dropped to abort.
- len  input  N_REQ*W  per-requester interval length; slice k is `len[k*W +: W]`; 0 encodes 2^W cycles.
- gnt  output  N_REQ  one-hot owner indication, high from LOAD through DONE.
- done  output  N_REQ  one-cycle pulse to the owner when its interval ends.
- busy  output  1  high in every state except IDLE.
- cnt  output  W  live counter value (debug/observation).

Behaviour:
- Reset (nrst=0, asynchronous):
  - state=IDLE; gnt=0; done=0; busy=0; cnt=0; owner=0.
  - last pointer = N_REQ-1, so requester 0 wins the first arbitration.
- States: IDLE, LOAD, COUNT, DONE.
- IDLE:
  - If any req bit is high, pick the first requester with req high, searching cyclically from last+1.
  - Register it as owner; next state LOAD.
  - If no req bit is high, stay in IDLE.
- LOAD (1 cycle):
  - gnt[owner]=1.
  - Counter load asserted with value (2^W - len[owner]) mod 2^W; `len` is sampled in this cycle only.
  - Next state COUNT.
- COUNT:
  - Counter enable=1 every cycle.
  - When cnt==2^W-1 with enable high, the counter wraps to 0 and the next state is DONE.
  - Cycles spent in COUNT = len, or 2^W when len=0.
- DONE (1 cycle):
  - done[owner]=1; gnt[owner] stays 1.
  - last := owner; next state IDLE.
- Latency, req rising (IDLE) to done pulse: 2 + len cycles, measured from the edge that samples req to the cycle done is high.
  - Examples: len=3 gives done in the 5th cycle after the sampling edge; len=0 with W=3 gives 10.
- Back-to-back operation:
  - After DONE there is always one IDLE cycle before the next LOAD.
  - The owner must drop req in the DONE cycle (or earlier) to avoid being re-served.
  - A requester still holding req in IDLE competes normally under round-robin.
- Abort:
  - If req[owner] falls while in LOAD or COUNT, the next state is IDLE with no done pulse; gnt drops on the same edge.
  - last := owner (round-robin advances). cnt is left as-is.
- Simultaneous requests: resolved strictly by round-robin. With N_REQ=2 and both requesters asserted continuously, grants alternate 0,1,0,1,…
- Non-owner behaviour:
  - req changes on non-owners during a transaction are ignored until IDLE.
  - len changes outside LOAD are ignored.
- Reset mid-operation: all outputs return to reset values immediately (asynchronous); the transaction is discarded and no done is produced.
- Counter semantics:
  - Synchronous; load has priority over enable; wrap-around is modulo 2^W.
  - cnt is held when neither load nor enable is asserted.
- Output invariants: gnt and done are one-hot or zero at all times; a done bit implies the matching gnt bit.

Decomposition:
- Shared package `intv_pkg`:
  - typedef enum state_t {IDLE, LOAD, COUNT, DONE}.
  - Localparam CNT_MAX = 2^W-1.
  - Function rr_pick(req, last) returning the next owner index.
- Sub-module `ld_counter`:
  - Parameter W; ports clk, nrst, ld, d[W], en, q[W].
  - Behavioural loadable up-counter with async active-low reset to 0, mirroring the team's sync-counter interface.
- The controller instantiates exactly one ld_counter.

Test Plan:
- Reset, then req[0]=1, len=3 → gnt[0] high from the LOAD cycle; cnt goes 5,6,7,0; done[0] pulses once; busy low one cycle later.
- req[1]=1, len=0, W=3 → cnt loads 0 and counts 0..7 then wraps (8 COUNT cycles); done[1] pulses in the 10th cycle after sampling.
- req=2'b11 held, len=1 for both → grant order 0,1,0,1; each done is separated by one IDLE cycle; done is never high for a non-owner.
- req[0]=1, len=5; drop req[0] after 2 COUNT cycles → no done; return to IDLE; a pending req[1] is granted next.
- Assert nrst=0 mid-COUNT with cnt=6 → gnt, done, busy and cnt all 0 immediately; after release with req[0] still high, requester 0 is granted first.
- Change len[0] from 2 to 7 during COUNT → interval unaffected (2 COUNT cycles); change of req[1] while owner=0 → no effect until IDLE.
